btn_event_arbiter: RTL and testbench

Turns the debounced push-button levels into a single ordered stream of button events for the matrix-calculator control FSM. For each button it tracks press/release, optionally classifies long presses, and arbitrates simultaneous events round-robin into a small FIFO. The consumer reads events over a valid/ready handshake, so no event is lost while it is busy.

---
 rtl/btn_evt_pkg.sv | 24 ++
 rtl/btn_evt_fifo.sv | 53 +++++
 rtl/btn_event_arbiter.sv | 177 +++++++++++++++++
 tb/tb_btn_event_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types for the button event arbiter: per-button FSM states, the queued
// event record, and the hold-counter width helper.
package btn_evt_pkg;

  // Wide enough for the largest supported button count (8).
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    PRESSED,
    HELD
  } btn_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             long_press;
  } btn_evt_t;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Show-ahead synchronous FIFO of button events; the head entry is visible on dout
// whenever empty is low. A push while full is accepted only alongside a pop.
module btn_evt_fifo
  import btn_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  btn_evt_t din,
  input  logic     pop,
  output btn_evt_t dout,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  btn_evt_t       mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Per-button press FSMs, pending slots and a round-robin arbiter feeding an event FIFO.
// Long-press classification is enabled by defining BTN_LONG_PRESS_EN.
module btn_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int unsigned NUM_BTN           = 5,
  parameter int unsigned LONG_PRESS_CYCLES = 100_000_000,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_BTN-1:0]         btn_level,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_BTN)-1:0] evt_btn,
  output logic                       evt_long,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int unsigned BW = $clog2(NUM_BTN);

  if (NUM_BTN < 2 || NUM_BTN > 8) begin : g_bad_num_btn
    $error("NUM_BTN must be in 2..8");
  end
  if (LONG_PRESS_CYCLES < 2) begin : g_bad_long_press
    $error("LONG_PRESS_CYCLES must be at least 2");
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned CW = cnt_width(LONG_PRESS_CYCLES);
  logic [CW-1:0] cnt_q [NUM_BTN];
  logic [CW-1:0] cnt_d [NUM_BTN];
`endif

  btn_state_t         st_q [NUM_BTN];
  btn_state_t         st_d [NUM_BTN];
  logic [NUM_BTN-1:0] raise;
  logic [NUM_BTN-1:0] raise_long;
  logic [NUM_BTN-1:0] pend_v;
  logic [NUM_BTN-1:0] pend_long;
  logic [NUM_BTN-1:0] grant;
  logic               grant_any;
  logic [BW-1:0]      grant_idx;
  logic [BW-1:0]      rr_ptr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               can_accept;
  logic               ovf_set;
  btn_evt_t           push_evt;
  btn_evt_t           head;

  always_comb begin
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      st_d[i]       = st_q[i];
      raise[i]      = 1'b0;
      raise_long[i] = 1'b0;
`ifdef BTN_LONG_PRESS_EN
      cnt_d[i]      = cnt_q[i];
`endif
      case (st_q[i])
        WAIT_REL: if (!btn_level[i]) st_d[i] = IDLE;
        IDLE: begin
          if (btn_level[i]) begin
            st_d[i] = PRESSED;
`ifdef BTN_LONG_PRESS_EN
            cnt_d[i] = '0;
`else
            raise[i] = 1'b1;
`endif
          end
        end
        PRESSED: begin
`ifdef BTN_LONG_PRESS_EN
          if (btn_level[i]) begin
            if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
            // Counter about to reach LONG_PRESS_CYCLES-1 this cycle.
            if (cnt_q[i] == CW'(LONG_PRESS_CYCLES - 2)) begin
              raise[i]      = 1'b1;
              raise_long[i] = 1'b1;
              st_d[i]       = HELD;
            end
          end else begin
            raise[i] = 1'b1;
            st_d[i]  = IDLE;
          end
`else
          if (!btn_level[i]) st_d[i] = IDLE;
`endif
        end
        HELD:    if (!btn_level[i]) st_d[i] = IDLE;
        default: st_d[i] = WAIT_REL;
      endcase
    end
  end

  assign pop        = !fifo_empty && evt_ready;
  assign can_accept = !fifo_full || pop;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (can_accept) begin
      for (int unsigned off = 0; off < NUM_BTN; off++) begin
        idx = (int'(rr_ptr) + off) % NUM_BTN;
        if (!grant_any && pend_v[idx]) begin
          grant_any  = 1'b1;
          grant_idx  = BW'(idx);
          grant[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    push_evt            = '0;
    push_evt.idx        = IDX_W'(grant_idx);
    push_evt.long_press = pend_long[grant_idx];
  end

  assign ovf_set = |(raise & pend_v & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        st_q[i] <= WAIT_REL;
`ifdef BTN_LONG_PRESS_EN
        cnt_q[i] <= '0;
`endif
      end
      pend_v    <= '0;
      pend_long <= '0;
      rr_ptr    <= '0;
      ovf       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        st_q[i] <= st_d[i];
`ifdef BTN_LONG_PRESS_EN
        cnt_q[i] <= cnt_d[i];
`endif
        // A new event lands in the slot even when the old one is granted this cycle.
        if (raise[i]) begin
          pend_v[i]    <= 1'b1;
          pend_long[i] <= raise_long[i];
        end else if (grant[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
      if (grant_any)
        rr_ptr <= (grant_idx == BW'(NUM_BTN - 1)) ? '0 : grant_idx + 1'b1;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  btn_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant_any),
    .din   (push_evt),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_btn   = head.idx[BW-1:0];
  assign evt_long  = head.long_press;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: vector table, directed corner sequences and random
// stimulus against a cycle-level reference model of the event stream.
module tb_btn_event_arbiter;

  localparam int N = 5;
  localparam int L = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_level;
  logic         evt_valid;
  logic         evt_ready;
  logic [2:0]   evt_btn;
  logic         evt_long;
  logic         ovf;
  logic         ovf_clr;

  btn_event_arbiter #(
    .NUM_BTN          (N),
    .LONG_PRESS_CYCLES(L),
    .FIFO_DEPTH       (D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_btn  (evt_btn),
    .evt_long (evt_long),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  typedef struct { int idx; bit lng; } ev_t;
  ev_t q[$];
  bit  armed [N];
  int  run   [N];
  bit  ldone [N];
  bit  pv    [N];
  bit  pl    [N];
  int  rr;
  bit  m_ovf;

  task automatic model_reset();
    for (int b = 0; b < N; b++) begin
      armed[b] = 0; run[b] = 0; ldone[b] = 0; pv[b] = 0; pl[b] = 0;
    end
    rr = 0;
    m_ovf = 0;
    q.delete();
  endtask

  task automatic model_step(input logic [N-1:0] lvl, input logic rdy, input logic clr);
    bit pop_now, can, set, ev, evl;
    int g;
    pop_now = (q.size() > 0) && rdy;
    can = (q.size() < D) || pop_now;
    g = -1;
    if (can)
      for (int off = 0; off < N; off++)
        if (g < 0 && pv[(rr + off) % N]) g = (rr + off) % N;
    if (pop_now) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back('{idx: g, lng: pl[g]});
      pv[g] = 0;
      rr = (g + 1) % N;
    end
    set = 0;
    for (int b = 0; b < N; b++) begin
      ev = 0; evl = 0;
      if (!armed[b]) begin
        if (!lvl[b]) armed[b] = 1;
      end else begin
`ifdef BTN_LONG_PRESS_EN
        if (lvl[b]) begin
          run[b]++;
          if (run[b] == L && !ldone[b]) begin ev = 1; evl = 1; ldone[b] = 1; end
        end else begin
          if (run[b] > 0 && !ldone[b]) ev = 1;
          run[b] = 0; ldone[b] = 0;
        end
`else
        if (lvl[b]) begin
          if (run[b] == 0) ev = 1;
          run[b]++;
        end else run[b] = 0;
`endif
      end
      if (ev) begin
        if (pv[b]) set = 1;
        pv[b] = 1;
        pl[b] = evl;
      end
    end
    if (set) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("model_valid", int'(evt_valid), int'(q.size() > 0));
    if (q.size() > 0) begin
      chk("model_btn", int'(evt_btn), q[0].idx);
      chk("model_long", int'(evt_long), int'(q[0].lng));
    end
    chk("model_ovf", int'(ovf), int'(m_ovf));
  endtask

  int cyc = 0;
  int seen = 0;
  int first_cyc = 0;
  int last_btn = 0;
  int last_long = 0;

  task automatic cycle(input logic [N-1:0] lvl, input logic rdy, input logic clr);
    btn_level = lvl;
    evt_ready = rdy;
    ovf_clr   = clr;
    model_step(lvl, rdy, clr);
    @(posedge clk);
    #1;
    cyc++;
    compare_model();
    if (evt_valid) begin
      if (seen == 0) first_cyc = cyc;
      seen++;
      last_btn  = int'(evt_btn);
      last_long = int'(evt_long);
    end
  endtask

  task automatic press(input int b, input logic rdy);
    logic [N-1:0] m;
    m = N'(1 << b);
    cycle(m, rdy, 1'b0);
    cycle(m, rdy, 1'b0);
    cycle('0, rdy, 1'b0);
    cycle('0, rdy, 1'b0);
  endtask

  // ---------------- vector table: round-robin ordering ----------------
  typedef struct { logic [N-1:0] lvl; bit ev; int eb; } vec_t;
  vec_t tbl [12];
  logic [N-1:0] lvl_tab [12] = '{5'b01011, 5'b01011, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                                 5'b00000, 5'b01001, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
`ifdef BTN_LONG_PRESS_EN
  int ev_tab [12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0};
  int eb_tab [12] = '{0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 3, 0};
  int s1_exp [6]  = '{0, 0, 0, 0, 1, 0};
  localparam int LONG_FIRST = 9;
  localparam int LONG_FLAG  = 1;
`else
  int ev_tab [12] = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
  int eb_tab [12] = '{0, 0, 1, 3, 0, 0, 0, 0, 0, 3, 0, 0};
  int s1_exp [6]  = '{0, 1, 0, 0, 0, 0};
  localparam int LONG_FIRST = 2;
  localparam int LONG_FLAG  = 0;
`endif
  logic [N-1:0] s1_lvl [6] = '{5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got_order[$];
    logic [N-1:0] r;
    logic rdy;
    int start;

    for (int k = 0; k < 12; k++) tbl[k] = '{lvl_tab[k], ev_tab[k] != 0, eb_tab[k]};

    rst_n = 1'b0; btn_level = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_btn", int'(evt_btn), 0);
    chk("rst_long", int'(evt_long), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    cycle('0, 1'b1, 1'b0);
    cycle('0, 1'b1, 1'b0);

    // Simultaneous events, then a pair that wraps the search from rr_ptr=4
    for (int k = 0; k < 12; k++) begin
      cycle(tbl[k].lvl, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_valid", k), int'(evt_valid), int'(tbl[k].ev));
      if (tbl[k].ev) chk($sformatf("tbl%0d_btn", k), int'(evt_btn), tbl[k].eb);
    end

    // Short press on button 2
    for (int k = 0; k < 6; k++) begin
      cycle(s1_lvl[k], 1'b1, 1'b0);
      chk($sformatf("short%0d_valid", k), int'(evt_valid), s1_exp[k]);
      if (s1_exp[k] != 0) begin
        chk("short_btn", int'(evt_btn), 2);
        chk("short_long", int'(evt_long), 0);
      end
    end

    // Button 4 held 20 cycles then released
    seen = 0;
    start = cyc;
    repeat (20) cycle(5'b10000, 1'b1, 1'b0);
    repeat (5) cycle('0, 1'b1, 1'b0);
    chk("hold_count", seen, 1);
    chk("hold_latency", first_cyc - start, LONG_FIRST);
    chk("hold_btn", last_btn, 4);
    chk("hold_long", last_long, LONG_FLAG);

    // Consumer stalled: fill FIFO, one pending, then overwrite it
    for (int b = 0; b < N; b++) press(b, 1'b0);
    chk("full_ovf", int'(ovf), 0);
    chk("full_valid", int'(evt_valid), 1);
    chk("full_head", int'(evt_btn), 0);
    press(4, 1'b0);
    chk("ovf_set", int'(ovf), 1);
    cycle('0, 1'b0, 1'b1);
    chk("ovf_clr", int'(ovf), 0);
    for (int k = 0; k < 8; k++) begin
      if (evt_valid) got_order.push_back(int'(evt_btn));
      cycle('0, 1'b1, 1'b0);
    end
    chk("drain_count", got_order.size(), 5);
    for (int k = 0; k < 5 && k < got_order.size(); k++)
      chk($sformatf("drain%0d_btn", k), got_order[k], k);

    // Asynchronous reset with queued events, button 1 held through it
    press(0, 1'b0);
    press(2, 1'b0);
    chk("prerst_valid", int'(evt_valid), 1);
    btn_level = 5'b00010;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(evt_valid), 0);
    chk("midrst_ovf", int'(ovf), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (3) cycle(5'b00010, 1'b1, 1'b0);
    repeat (3) cycle('0, 1'b1, 1'b0);
    chk("held_rst_events", seen, 0);
    press(1, 1'b1);
    repeat (3) cycle('0, 1'b1, 1'b0);
    chk("after_rst_count", seen, 1);
    chk("after_rst_btn", last_btn, 1);
    chk("after_rst_long", last_long, 0);

    // Random traffic with stall phases
    r = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      if ((i / 50) % 3 == 2) rdy = ($urandom_range(0, 7) == 0);
      else                   rdy = ($urandom_range(0, 3) != 0);
      cycle(r, rdy, $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
